unidade_controle_jogo: RTL
==========================

UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 SHALL have ports `clock` (in, 1, sole clock, all state changes on rising edge) and `reset` (in, 1, synchronous, active-high).
REQ-002 SHALL have inputs `iniciar`, `tem_jogada`, `macro_vencida`, `micro_jogada`, `fim_jogo`, `fimT` (in, 1 each): start request and the datapath status flags of the same names.
REQ-003 SHALL have outputs `zeraEdge`, `zeraR_micro`, `zeraR_macro`, `zeraFlipFlopT`, `zeraT` (out, 1 each): datapath clears.
REQ-004 SHALL have outputs `registraR_micro`, `registraR_macro`, `sinal_macro`, `sinal_valida_macro`, `troca_jogador` (out, 1 each): datapath load, select and toggle controls.
REQ-005 SHALL have outputs `we_board`, `we_board_state`, `contaT` (out, 1 each): memory writes and timer count enable.
REQ-006 SHALL have outputs `pronto` (out, 1, game over) and `db_estado` (out, 5, state code).

Function
REQ-007 SHALL be a Moore FSM; every output SHALL be decoded from the current state only.
REQ-008 SHALL deassert any output not listed for a state.
REQ-009 SHALL use these states and `db_estado` codes: INICIAL 00, PREPARA 01, ESPERA_MACRO 02, REGISTRA_MACRO 03, LE_MACRO 04, VALIDA_MACRO 05, ESPERA_MICRO 06, REGISTRA_MICRO 07, LE_MICRO 08, VALIDA_MICRO 09, ESCREVE_JOGADA 0A, ATUALIZA_MACRO 0B, LE_FIM 0C, VERIFICA_FIM 0D, TROCA_JOGADOR 0E, FIM_JOGO 0F, TIMEOUT 10.
REQ-010 SHALL decode an unused code as INICIAL on the next edge.
REQ-011 INICIAL SHALL go to PREPARA if `iniciar`=1, else stay.
REQ-012 PREPARA SHALL assert `zeraEdge`, `zeraR_micro`, `zeraR_macro`, `zeraFlipFlopT`, then go to ESPERA_MACRO.
REQ-013 ESPERA_MACRO SHALL go to REGISTRA_MACRO on `tem_jogada`=1, else stay; it has no timeout.
REQ-014 REGISTRA_MACRO SHALL assert `registraR_macro` and `sinal_macro` (load from buttons), then go to LE_MACRO.
REQ-015 LE_MACRO SHALL assert `sinal_valida_macro` (one-cycle board_state read latency), then go to VALIDA_MACRO.
REQ-016 VALIDA_MACRO SHALL assert `sinal_valida_macro`; if `macro_vencida`=1 it SHALL go to ESPERA_MACRO (free choice), else to ESPERA_MICRO.
REQ-017 ESPERA_MICRO SHALL assert `contaT`, with priority `tem_jogada`=1 -> REGISTRA_MICRO, else `fimT`=1 -> TIMEOUT, else stay.
REQ-018 REGISTRA_MICRO SHALL assert `registraR_micro`, then go to LE_MICRO.
REQ-019 LE_MICRO SHALL go to VALIDA_MICRO (board read latency).
REQ-020 VALIDA_MICRO SHALL go to ESPERA_MICRO if `micro_jogada`=1 (cell occupied, move rejected, same player), else to ESCREVE_JOGADA.
REQ-021 ESCREVE_JOGADA SHALL assert `we_board` for exactly one cycle, then go to ATUALIZA_MACRO.
REQ-022 ATUALIZA_MACRO SHALL assert `we_board_state` and `sinal_valida_macro` for one cycle, then go to LE_FIM.
REQ-023 LE_FIM SHALL assert `sinal_valida_macro`, then go to VERIFICA_FIM.
REQ-024 VERIFICA_FIM SHALL go to FIM_JOGO if `fim_jogo`=1, else to TROCA_JOGADOR.
REQ-025 TROCA_JOGADOR SHALL assert `troca_jogador` and `registraR_macro` with `sinal_macro`=0 (macro <= micro), then go to LE_MACRO.
REQ-026 TIMEOUT SHALL assert `troca_jogador` for one cycle, then go to ESPERA_MICRO; the macro register SHALL be unchanged.
REQ-027 `zeraT` SHALL be 1 in every state except ESPERA_MICRO, so each micro wait starts from count 0.
REQ-028 FIM_JOGO SHALL assert `pronto`; it SHALL go to PREPARA on `iniciar`=1, else stay.
REQ-029 `tem_jogada` pulses arriving outside ESPERA_MACRO/ESPERA_MICRO SHALL be ignored, not queued.
REQ-030 `troca_jogador` SHALL never be high for two consecutive cycles.

Reset
REQ-031 `reset`=1 at a rising edge SHALL force INICIAL from any state, including mid-write, overriding all inputs.
REQ-032 In INICIAL all control outputs SHALL be 0 except `zeraT`=1, with `pronto`=0 and `db_estado`=00.
REQ-033 Reset SHALL NOT itself clear datapath registers; PREPARA performs that.

Verification
REQ-034 Reset, `iniciar` pulse, button 4 pulse, `macro_vencida`=0 -> `db_estado` sequence 01,02,03,04,05,06; `registraR_macro`=1 in 03 only.
REQ-035 In 06, button pulse, `micro_jogada`=0, `fim_jogo`=0 -> 07,08,09,0A,0B,0C,0D,0E,04; `we_board`, `we_board_state`, `troca_jogador` each high exactly one cycle.
REQ-036 In 09 with `micro_jogada`=1 -> return to 06, no `we_board`, no `troca_jogador`.
REQ-037 Hold 06 with no move, `fimT`=1 -> 10 then 06; one `troca_jogador` pulse; `zeraT`=1 in 10; with `tem_jogada` and `fimT` both 1 -> 07 wins.
REQ-038 `fim_jogo`=1 in 0D -> 0F, `pronto`=1 held; `iniciar` -> 01.
REQ-039 `reset` asserted while in 0A -> next state 00, `we_board`=0.

Source files
------------

// File: rtl/unidade_controle_jogo.sv
// Control unit for the two-level tic-tac-toe game: a Moore FSM that sequences
// macro/micro move capture, validation, board writes, end detection and timeouts.
module unidade_controle_jogo (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       macro_vencida,
    input  logic       micro_jogada,
    input  logic       fim_jogo,
    input  logic       fimT,
    output logic       zeraEdge,
    output logic       zeraR_micro,
    output logic       zeraR_macro,
    output logic       zeraFlipFlopT,
    output logic       zeraT,
    output logic       registraR_micro,
    output logic       registraR_macro,
    output logic       sinal_macro,
    output logic       sinal_valida_macro,
    output logic       troca_jogador,
    output logic       we_board,
    output logic       we_board_state,
    output logic       contaT,
    output logic       pronto,
    output logic [4:0] db_estado
);

    typedef enum logic [4:0] {
        Inicial       = 5'h00,
        Prepara       = 5'h01,
        EsperaMacro   = 5'h02,
        RegistraMacro = 5'h03,
        LeMacro       = 5'h04,
        ValidaMacro   = 5'h05,
        EsperaMicro   = 5'h06,
        RegistraMicro = 5'h07,
        LeMicro       = 5'h08,
        ValidaMicro   = 5'h09,
        EscreveJogada = 5'h0A,
        AtualizaMacro = 5'h0B,
        LeFim         = 5'h0C,
        VerificaFim   = 5'h0D,
        TrocaJogador  = 5'h0E,
        FimJogo       = 5'h0F,
        Timeout       = 5'h10
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [13:0] saidas_q;

    // Output bundle order matches the concatenation driven onto the ports below.
    function automatic logic [13:0] decodifica(estado_t e);
        logic z_edge, z_rmicro, z_rmacro, z_fft, z_t, r_micro, r_macro;
        logic s_macro, s_valida, troca, we_b, we_bs, conta, fim;
        z_edge   = 1'b0;
        z_rmicro = 1'b0;
        z_rmacro = 1'b0;
        z_fft    = 1'b0;
        z_t      = 1'b1;
        r_micro  = 1'b0;
        r_macro  = 1'b0;
        s_macro  = 1'b0;
        s_valida = 1'b0;
        troca    = 1'b0;
        we_b     = 1'b0;
        we_bs    = 1'b0;
        conta    = 1'b0;
        fim      = 1'b0;
        case (e)
            Prepara: begin
                z_edge   = 1'b1;
                z_rmicro = 1'b1;
                z_rmacro = 1'b1;
                z_fft    = 1'b1;
            end
            RegistraMacro: begin
                r_macro = 1'b1;
                s_macro = 1'b1;
            end
            LeMacro, ValidaMacro, LeFim: s_valida = 1'b1;
            EsperaMicro: begin
                z_t   = 1'b0;
                conta = 1'b1;
            end
            RegistraMicro: r_micro = 1'b1;
            EscreveJogada: we_b = 1'b1;
            AtualizaMacro: begin
                we_bs    = 1'b1;
                s_valida = 1'b1;
            end
            TrocaJogador: begin
                troca   = 1'b1;
                r_macro = 1'b1;
            end
            FimJogo: fim = 1'b1;
            Timeout: troca = 1'b1;
            default: ;
        endcase
        return {z_edge, z_rmicro, z_rmacro, z_fft, z_t, r_micro, r_macro,
                s_macro, s_valida, troca, we_b, we_bs, conta, fim};
    endfunction

    always_comb begin
        estado_d = Inicial;
        case (estado_q)
            Inicial:       estado_d = iniciar ? Prepara : Inicial;
            Prepara:       estado_d = EsperaMacro;
            EsperaMacro:   estado_d = tem_jogada ? RegistraMacro : EsperaMacro;
            RegistraMacro: estado_d = LeMacro;
            LeMacro:       estado_d = ValidaMacro;
            ValidaMacro:   estado_d = macro_vencida ? EsperaMacro : EsperaMicro;
            EsperaMicro: begin
                if (tem_jogada)  estado_d = RegistraMicro;
                else if (fimT)   estado_d = Timeout;
                else             estado_d = EsperaMicro;
            end
            RegistraMicro: estado_d = LeMicro;
            LeMicro:       estado_d = ValidaMicro;
            ValidaMicro:   estado_d = micro_jogada ? EsperaMicro : EscreveJogada;
            EscreveJogada: estado_d = AtualizaMacro;
            AtualizaMacro: estado_d = LeFim;
            LeFim:         estado_d = VerificaFim;
            VerificaFim:   estado_d = fim_jogo ? FimJogo : TrocaJogador;
            TrocaJogador:  estado_d = LeMacro;
            FimJogo:       estado_d = iniciar ? Prepara : FimJogo;
            Timeout:       estado_d = EsperaMicro;
            default:       estado_d = Inicial;
        endcase
    end

    // Outputs are registered from the next state so they stay aligned with estado_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= Inicial;
            saidas_q <= decodifica(Inicial);
        end else begin
            estado_q <= estado_d;
            saidas_q <= decodifica(estado_d);
        end
    end

    assign {zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraT, registraR_micro,
            registraR_macro, sinal_macro, sinal_valida_macro, troca_jogador, we_board,
            we_board_state, contaT, pronto} = saidas_q;
    assign db_estado = estado_q;

endmodule
